// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; define UART_TX_ARB_FIXED_PRIO_EN for fixed priority
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int ACTIVE_TIMEOUT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [NUM_REQ*8-1:0] i_req_data,
   output logic [NUM_REQ-1:0]   o_req_ack,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [7:0]           o_tx_byte,
   output logic                 o_tx_dv,
   input  logic                 i_tx_active,
   input  logic                 i_tx_done,
   output logic                 o_busy,
   output logic                 o_timeout
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] TO_LAST  = 32'(ACTIVE_TIMEOUT - 2);
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, GAP} state_t;
   state_t state;
   logic [31:0] cnt;
   logic [IW-1:0] win;
   logic [NUM_REQ-1:0] win_oh;
   assign win_oh = NUM_REQ'(1) << win;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
   // lowest-index pending requester wins
   always_comb begin
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (i_req_valid[IW'(i)]) win = IW'(i);
   end
`else
   logic [IW-1:0] last;
   // nearest pending requester above the last winner wins, wrapping around
   always_comb begin
      win = last;
      for (int i = NUM_REQ; i >= 1; i--)
         if (i_req_valid[IW'((int'(last) + i) % NUM_REQ)]) win = IW'((int'(last) + i) % NUM_REQ);
   end
`endif
   // launch one byte per grant, wait for the transmitter, then hold off for the gap
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         o_req_ack <= '0;
         o_grant   <= '0;
         o_tx_byte <= 8'h00;
         o_tx_dv   <= 1'b0;
         o_busy    <= 1'b0;
         o_timeout <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
         last      <= IW'(NUM_REQ - 1);
`endif
      end else begin
         o_req_ack <= '0;
         o_tx_dv   <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE: if (|i_req_valid) begin
               state     <= LAUNCH;
               o_tx_dv   <= 1'b1;
               o_tx_byte <= i_req_data[{win, 3'b000} +: 8];
               o_req_ack <= win_oh;
               o_grant   <= win_oh;
               o_busy    <= 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
               last      <= win;
`endif
            end
            LAUNCH: begin
               state <= WAIT_ACTIVE;
               cnt   <= '0;
            end
            WAIT_ACTIVE: if (i_tx_active) state <= WAIT_DONE;
               else if (cnt == TO_LAST) begin
                  state     <= IDLE;
                  o_timeout <= 1'b1;
                  o_grant   <= '0;
                  o_busy    <= 1'b0;
               end else cnt <= cnt + 1;
            WAIT_DONE: if (i_tx_done) begin
               if (GAP_CYCLES > 0) begin
                  state <= GAP;
                  cnt   <= '0;
               end else begin
                  state   <= IDLE;
                  o_grant <= '0;
                  o_busy  <= 1'b0;
               end
            end
            GAP: if (cnt == GAP_LAST) begin
                  state   <= IDLE;
                  o_grant <= '0;
                  o_busy  <= 1'b0;
               end else cnt <= cnt + 1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `UART_Transmitter` among up to `NUM_REQ` byte sources, such as loopback echo, status reporter and debug dump. It sits between the requesters and the transmitter's `i_tx_byte`/`i_tx_dv` inputs, and monitors `o_tx_active`/`o_tx_done`. It issues exactly one byte per grant, then enforces a configurable idle gap before the next launch.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYCLES`, default 0: idle clocks inserted after `i_tx_done` before the next launch, 0..65535.
- `ACTIVE_TIMEOUT`, default 4: clocks to wait for `i_tx_active` after a launch before abandoning the byte, ≥2.

Ports:
- `i_clk` in 1: system clock. Single clock domain.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_valid` in NUM_REQ: per-requester byte-pending flag. Held until acked.
- `i_req_data` in NUM_REQ*8: requester k's byte is at `[8k+7:8k]`. Stable while valid.
- `o_req_ack` out NUM_REQ: one-cycle pulse; byte k accepted.
- `o_grant` out NUM_REQ: one-hot owner of the transmitter, or 0 when none.
- `o_tx_byte` out 8: to transmitter `i_tx_byte`.
- `o_tx_dv` out 1: to transmitter `i_tx_dv`. One-cycle pulse.
- `i_tx_active` in 1: from transmitter `o_tx_active`.
- `i_tx_done` in 1: from transmitter `o_tx_done`. One-cycle pulse.
- `o_busy` out 1: high in any state other than IDLE.
- `o_timeout` out 1: one-cycle pulse when `ACTIVE_TIMEOUT` expires.

## Operation
- States: IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, GAP.
- IDLE: if any `i_req_valid` is set, select the winner and go to LAUNCH. Otherwise stay.
- Round-robin: search from `(last+1) mod NUM_REQ` upward, with wrap. `last` updates to the winner.
- LAUNCH (exactly 1 cycle):
  - `o_tx_dv`=1 and `o_tx_byte`=winner's data, registered.
  - `o_req_ack[winner]`=1.
  - `o_grant`=winner one-hot; it holds until the state returns to IDLE.
  - Next state is WAIT_ACTIVE, and the timeout counter is cleared.
- WAIT_ACTIVE:
  - `i_tx_active`=1 → WAIT_DONE.
  - Counter reaches `ACTIVE_TIMEOUT` → pulse `o_timeout` and go to IDLE. The byte is considered lost and is not re-acked.
- WAIT_DONE: `i_tx_done`=1 → GAP if `GAP_CYCLES`>0, else IDLE.
- GAP: count 0..`GAP_CYCLES`-1, then go to IDLE.
- `o_tx_byte` holds its last value outside LAUNCH.
- Requester inputs are ignored outside IDLE. Newly valid requesters queue implicitly by holding valid.
- A requester that drops valid before ack is simply not served. No error is raised.
- Reset values:
  - State = IDLE.
  - `last` = NUM_REQ-1, so requester 0 wins first after reset.
  - `o_req_ack`, `o_grant`, `o_tx_dv`, `o_busy`, `o_timeout` = 0.
  - `o_tx_byte` = 8'h00.
  - Counters = 0.
- Reset mid-transfer forces IDLE at the next edge. The transmitter is not reset by this block, so a byte already in flight completes on the wire unowned.

## Timing
- Request-to-`o_tx_dv` latency: 1 cycle. A request sampled in IDLE at edge n produces LAUNCH outputs after edge n+1.
- Back-to-back throughput with `GAP_CYCLES`=0: the next LAUNCH comes 2 cycles after the `i_tx_done` cycle (done → IDLE → LAUNCH).
- `i_tx_done` arriving in WAIT_ACTIVE (not legal from the transmitter) is ignored. Only `i_tx_active` advances the state.
- `i_tx_active` and timeout expiry in the same cycle: `i_tx_active` wins, so no `o_timeout`.
- Fair bound: any held request is launched within NUM_REQ grants.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest index wins. `last` is not stored.
  - Undefined: round-robin as specified above.
  - All other behaviour is identical in both builds.

## Test plan
- **Single request after reset:** `i_req_valid`=4'b0100, data[23:16]=8'h5A.
  - Expect `o_tx_dv` and `o_req_ack`=4'b0100 in the same cycle, 1 cycle after the request.
  - Expect `o_tx_byte`=8'h5A and `o_grant`=4'b0100 until return to IDLE.
- **Round-robin:** all four valid continuously, bytes 8'h10..8'h13, transmitter model with 217×10 cycles per byte.
  - Expect launch order 0,1,2,3,0.
  - With `UART_TX_ARB_FIXED_PRIO_EN` defined, expect 0,0,0.
- **Gap:** `GAP_CYCLES`=5, two queued requests. Expect exactly 5+2 cycles from `i_tx_done` to the second `o_tx_dv`.
- **Timeout:** `i_tx_active` tied 0, `ACTIVE_TIMEOUT`=4.
  - Expect an `o_timeout` pulse 4 cycles after LAUNCH, then `o_busy`=0.
  - A subsequent request is served normally.
- **Reset mid-WAIT_DONE:** assert `i_reset` for 1 cycle.
  - Next cycle all outputs are at their reset values.
  - `i_tx_done` arriving later is ignored (stays IDLE, no ack).
- **Simultaneous `i_tx_active` and timeout edge:** expect WAIT_DONE entered and no `o_timeout`.
